// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings and byte-lane mask helper for the data memory LSU
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << lo;
            F3_H, F3_HU: m = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane mask, store replication, fault detect and load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] rdata
);

    logic       illegal;
    logic       misaligned;
    logic [7:0] bsel;
    logic [15:0] hsel;

    always_comb begin
        // A store (even when a load is also requested) is judged by the store rules
        if (mem_we)
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);

        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = |addr_lo;
            default:     misaligned = 1'b0;
        endcase

        misalign = (mem_we | mem_re) & (illegal | misaligned);
    end

    always_comb begin
        byte_en = byte_mask(funct3, addr_lo);
        case (funct3)
            F3_B:    wdata_rep = {4{wdata[7:0]}};
            F3_H:    wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    always_comb begin
        bsel = rword[{addr_lo, 3'b000} +: 8];
        hsel = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            F3_B:    rdata = {{24{bsel[7]}}, bsel};
            F3_H:    rdata = {{16{hsel[15]}}, hsel};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'h0, bsel};
            F3_HU:   rdata = {16'h0, hsel};
            default: rdata = 32'h0;
        endcase
        if (!mem_re || misalign)
            rdata = 32'h0;
    end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - data memory with lane-masked stores, extended loads, fault capture and store count
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_we,
    input  logic             mem_re,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             misalign,
    output logic             fault_sticky,
    output logic [31:0]      fault_addr,
    output logic [31:0]      store_cnt
);

    localparam int IW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [IW-1:0]    idx;
    logic [Width-1:0] rword;
    logic [3:0]       byte_en;
    logic [Width-1:0] wdata_rep;
    logic             wr_commit;
    logic             fault_q;
    logic [31:0]      fault_addr_q;
    logic [31:0]      cnt_q;

    // Upper address bits are ignored so the array aliases modulo Depth
    assign idx   = addr[IW+1:2];
    assign rword = mem[idx];

    lsu_align u_align (
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .funct3    (funct3),
        .addr_lo   (addr[1:0]),
        .wdata     (wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .misalign  (misalign),
        .rdata     (rdata)
    );

    assign wr_commit = mem_we & ~misalign;

    always_ff @(posedge clk) begin
        if (!rst && wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            cnt_q        <= 32'h0;
        end else begin
            if (misalign && !fault_q) begin
                fault_q      <= 1'b1;
                fault_addr_q <= addr;
            end
            if (wr_commit)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    assign fault_sticky = fault_q;
    assign fault_addr   = fault_addr_q;
    assign store_cnt    = cnt_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu against a byte-addressed reference model
module tb_data_mem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misalign;
    logic        fault_sticky;
    logic [31:0] fault_addr;
    logic [31:0] store_cnt;

    data_mem_lsu #(.Width(32), .Depth(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .misalign     (misalign),
        .fault_sticky (fault_sticky),
        .fault_addr   (fault_addr),
        .store_cnt    (store_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        fs;
        logic [31:0] fa;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mbytes [1024];
    logic        m_fs;
    logic [31:0] m_fa;
    logic [31:0] m_cnt;

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_mis(input logic we, input logic re, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic ill;
        int   sz;
        if (!(we || re))
            return 1'b0;
        if (we)
            ill = (f3 > 3'd2);
        else
            ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        sz = acc_size(f3);
        return ill || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic re, input logic mis, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] m;
        int          sz;
        int          b;
        if (!re || mis)
            return 32'h0;
        sz = acc_size(f3);
        b  = int'(a % 1024);
        v  = 32'h0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(mbytes[b + i]) << (8 * i));
        if (!f3[2] && sz < 4) begin
            m = (32'h1 << (8 * sz)) - 32'h1;
            if (v[8*sz-1])
                v = v | ~m;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin : mon
            exp_t e;
            e = sbq.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
            chk("fault_sticky", {31'h0, fault_sticky}, {31'h0, e.fs});
            chk("fault_addr", fault_addr, e.fa);
            chk("store_cnt", store_cnt, e.cnt);
        end
    end

    task automatic cycle(input logic we, input logic re, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input bit mid_rst = 1'b0);
        exp_t e;
        logic mis;
        mem_we = we;
        mem_re = re;
        funct3 = f3;
        addr   = a;
        wdata  = d;
        if (mid_rst) begin
            #1;
            rst   = 1'b1;
            m_fs  = 1'b0;
            m_fa  = 32'h0;
            m_cnt = 32'h0;
        end
        mis     = model_mis(we, re, f3, a);
        e.rdata = model_load(re, mis, f3, a);
        e.mis   = mis;
        e.fs    = m_fs;
        e.fa    = m_fa;
        e.cnt   = m_cnt;
        sbq.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (mis && !m_fs) begin
                m_fs = 1'b1;
                m_fa = a;
            end
            if (we && !mis) begin
                for (int i = 0; i < acc_size(f3); i++)
                    mbytes[int'(a % 1024) + i] = d[8*i +: 8];
                m_cnt = m_cnt + 32'd1;
            end
        end
        #1;
        if (mid_rst)
            rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        rst    = 1'b1;
        mem_we = 1'b0;
        mem_re = 1'b0;
        funct3 = 3'b000;
        addr   = 32'h0;
        wdata  = 32'h0;
        m_fs   = 1'b0;
        m_fa   = 32'h0;
        m_cnt  = 32'h0;
        for (int i = 0; i < 1024; i++)
            mbytes[i] = 8'h00;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, F3_W, 32'h10, 32'h0);
        cycle(1'b1, 1'b0, F3_W, 32'h10, 32'h1);
        rst = 1'b0;

        for (int w = 0; w < 256; w++)
            cycle(1'b1, 1'b0, F3_W, 32'(w * 4), $urandom);

        cycle(1'b1, 1'b0, F3_W, 32'h10, 32'hDEADBEEF);
        cycle(1'b0, 1'b1, F3_W, 32'h10, 32'h0);

        cycle(1'b1, 1'b0, F3_W,  32'h10, 32'h0);
        cycle(1'b1, 1'b0, F3_B,  32'h13, 32'h80);
        cycle(1'b0, 1'b1, F3_B,  32'h13, 32'h0);
        cycle(1'b0, 1'b1, F3_BU, 32'h13, 32'h0);
        cycle(1'b0, 1'b1, F3_W,  32'h10, 32'h0);

        cycle(1'b1, 1'b0, F3_W,  32'h20, 32'hAAAAAAAA);
        cycle(1'b1, 1'b0, F3_H,  32'h22, 32'h1234);
        cycle(1'b0, 1'b1, F3_W,  32'h20, 32'h0);
        cycle(1'b0, 1'b1, F3_HU, 32'h22, 32'h0);

        cycle(1'b1, 1'b0, F3_W,  32'h31, 32'h55AA55AA);
        cycle(1'b0, 1'b1, F3_W,  32'h30, 32'h0);
        cycle(1'b0, 1'b1, F3_H,  32'h45, 32'h0);
        cycle(1'b1, 1'b0, F3_BU, 32'h44, 32'h0);
        cycle(1'b0, 1'b0, F3_W,  32'h0,  32'h0);

        cycle(1'b1, 1'b0, F3_W,  32'h40, 32'h5);
        cycle(1'b1, 1'b1, F3_W,  32'h40, 32'h1);
        cycle(1'b0, 1'b1, F3_W,  32'h40, 32'h0);

        force dut.cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        cycle(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        release dut.cnt_q;
        cycle(1'b1, 1'b0, F3_W, 32'h60, 32'hCAFEF00D);
        cycle(1'b0, 1'b1, F3_W, 32'h60, 32'h0);

        cycle(1'b1, 1'b0, F3_W, 32'h50, 32'h12345678, 1'b1);
        cycle(1'b0, 1'b1, F3_W, 32'h50, 32'h0);

        for (int n = 0; n < 600; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0)
                ra[1:0] = 2'b00;
            rf = 3'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rf, ra, $urandom);
        end

        cycle(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
